// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a 2-flop synchroniser, a stability
// counter that accepts a new level only after it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles, and registered press/release pulses.
module btn_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Two-flop synchroniser; resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Sampled level, 1 = pressed.
    assign s = ~sync2_q[g];

    // Stability counter: any agreement with the accepted level clears the
    // count, so a reversion keeps no partial credit. The count saturates at
    // CNT_MAX, where the new level is accepted and a pulse is raised.
    always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        level_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter, level and pulse registers; pulses coincide with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule
